cordic_atanh: RTL and testbench
===============================

CORDIC_ATANH -- requirements
Module: cordic_atanh

Interface
REQ-001 Parameter: WORD_SZ, default 32, datapath and input/output word width.
REQ-002 Parameter: FRAC_SZ, default 15, fractional bits of all fixed-point values (Q15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  block accepts an operand this cycle.
REQ-007 Port: in_data  input  WORD_SZ  signed Q15 operand t; the function computes atanh(t).
REQ-008 Port: out_valid  output  1  out_data and out_sat are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out_data  output  WORD_SZ  signed Q15 result, atanh(t).
REQ-011 Port: out_sat  output  1  operand was clamped to the convergence limit.

Function
REQ-012 The block SHALL implement an iterative hyperbolic CORDIC in vectoring mode, with one iteration per clock.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE->RUN SHALL occur on in_valid&&in_ready, loading x=1.0 (32768), y=clamped operand, z=0, iteration counter=0.
REQ-015 Clamp rule: if in_data>IN_LIMIT (26214, i.e. 0.8), y=+IN_LIMIT; if in_data<-IN_LIMIT, y=-IN_LIMIT; out_sat latches 1 in both cases, else 0.
REQ-016 RUN SHALL execute exactly 17 iterations over the shift sequence 1,2,3,4,4,5,...,13,13,14,15 (indices 4 and 13 repeated).
REQ-017 Iteration rule, shift i: if y>=0: x-=y>>>i, y-=x>>>i, z+=ATANH_LUT[i]; else x+=y>>>i, y+=x>>>i, z-=ATANH_LUT[i]. Shifts SHALL be arithmetic and all updates SHALL use the pre-update values.
REQ-018 After the 17th iteration the FSM SHALL enter DONE with out_data=z; out_valid SHALL rise exactly 17 clocks after the accepting edge.
REQ-019 DONE SHALL hold out_data and out_sat stable until out_valid&&out_ready, then return to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; operands are not accepted while a result is pending (minimum 19 cycles per operation).
REQ-021 in_valid asserted in RUN or DONE SHALL be ignored with no state change.
REQ-022 All arithmetic SHALL be WORD_SZ-bit two's complement with no saturation internal to the datapath; wrap cannot occur within the clamped range.
REQ-023 Accuracy: |out_data - round(32768*atanh(t_clamped))| <= 8 LSB.

Reset
REQ-024 rst_n low SHALL force state=IDLE, x=y=z=0, counter=0, out_data=0, out_sat=0, out_valid=0; in_ready SHALL be 1 once rst_n is high.
REQ-025 Reset during RUN or DONE SHALL abort the operation; no result for the aborted operand SHALL ever appear.

Structure
REQ-026 Package cordic_pkg SHALL hold WORD_SZ, FRAC_SZ, IN_LIMIT=26214, ITER_CNT=17, the FSM state enum, and ATANH_LUT[1..15] in Q15 = 18000, 8369, 4118, 2051, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1.
REQ-027 One combinational sub-module, cordic_hyp_vec_stage (inputs x, y, z, shift, lut; outputs x', y', z'), SHALL implement REQ-017. The top SHALL instantiate it once, drive its shift input from a counter-indexed shift table, and hold the FSM and registers itself.

Verification
REQ-028 in_data=16384 (0.5) -> out_data=18000±8, out_sat=0, out_valid 17 clocks after the accepting edge.
REQ-029 in_data=-16384 -> out_data=-18000±8, out_sat=0; in_data=0 -> out_data=0±8.
REQ-030 in_data=30000 -> clamp applies, out_data=36000±8 (atanh 0.8), out_sat=1; in_data=-40000 -> out_data=-36000±8, out_sat=1.
REQ-031 out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0, and a new in_valid pulse is ignored; out_ready=1 -> IDLE on the next edge, then the next operand is accepted.
REQ-032 rst_n pulsed low at iteration 8 of a RUN -> out_valid stays 0 and out_data=0; after release, in_ready=1 and a fresh operand 8192 yields out_data=8369±8 (atanh 0.25).

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and lookup tables for the hyperbolic CORDIC atanh block.
package cordic_pkg;

    localparam int WORD_SZ  = 32;
    localparam int FRAC_SZ  = 15;
    localparam int IN_LIMIT = 26214;
    localparam int ITER_CNT = 17;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // atanh(2^-i) in Q15, indexed by shift amount i.
    localparam int ATANH_LUT [1:15] = '{
        18000, 8369, 4118, 2051, 1024, 512, 256, 128,
        64, 32, 16, 8, 4, 2, 1
    };

    // Shifts 4 and 13 repeat so the hyperbolic iteration converges.
    function automatic logic [3:0] shift_of(input logic [4:0] cnt);
        case (cnt)
            5'd0:    shift_of = 4'd1;
            5'd1:    shift_of = 4'd2;
            5'd2:    shift_of = 4'd3;
            5'd3:    shift_of = 4'd4;
            5'd4:    shift_of = 4'd4;
            5'd5:    shift_of = 4'd5;
            5'd6:    shift_of = 4'd6;
            5'd7:    shift_of = 4'd7;
            5'd8:    shift_of = 4'd8;
            5'd9:    shift_of = 4'd9;
            5'd10:   shift_of = 4'd10;
            5'd11:   shift_of = 4'd11;
            5'd12:   shift_of = 4'd12;
            5'd13:   shift_of = 4'd13;
            5'd14:   shift_of = 4'd13;
            5'd15:   shift_of = 4'd14;
            default: shift_of = 4'd15;
        endcase
    endfunction

endpackage

// File: rtl/cordic_hyp_vec_stage.sv
// One combinational hyperbolic vectoring micro-rotation; all outputs use pre-update x/y/z.
module cordic_hyp_vec_stage #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic [3:0]   shift,
    input  logic [W-1:0] lut,
    output logic [W-1:0] x_next,
    output logic [W-1:0] y_next,
    output logic [W-1:0] z_next
);

    logic [W-1:0] x_sh;
    logic [W-1:0] y_sh;
    logic         y_pos;

    assign x_sh  = $signed(x) >>> shift;
    assign y_sh  = $signed(y) >>> shift;
    assign y_pos = ~y[W-1];

    assign x_next = y_pos ? x - y_sh : x + y_sh;
    assign y_next = y_pos ? y - x_sh : y + x_sh;
    assign z_next = y_pos ? z + lut  : z - lut;

endmodule

// File: rtl/cordic_atanh.sv
// Iterative hyperbolic CORDIC computing atanh(t) in Q15, one iteration per clock, valid/ready handshake.
module cordic_atanh
    import cordic_pkg::*;
#(
    parameter int WORD_SZ = cordic_pkg::WORD_SZ,
    parameter int FRAC_SZ = cordic_pkg::FRAC_SZ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_SZ-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_SZ-1:0] out_data,
    output logic               out_sat
);

    localparam logic [WORD_SZ-1:0] LIM_POS = WORD_SZ'(IN_LIMIT);
    localparam logic [WORD_SZ-1:0] LIM_NEG = WORD_SZ'(-IN_LIMIT);
    localparam logic [WORD_SZ-1:0] ONE     = WORD_SZ'(1) << FRAC_SZ;
    localparam logic [4:0]         LAST    = 5'(ITER_CNT - 1);

    state_t             state;
    logic [WORD_SZ-1:0] x, y, z;
    logic [4:0]         cnt;
    logic [3:0]         shift;
    logic [WORD_SZ-1:0] lut;
    logic [WORD_SZ-1:0] x_next, y_next, z_next;
    logic               over, under;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign shift = shift_of(cnt);
    assign lut   = WORD_SZ'(ATANH_LUT[shift]);
    assign over  = $signed(in_data) > $signed(LIM_POS);
    assign under = $signed(in_data) < $signed(LIM_NEG);

    cordic_hyp_vec_stage #(.W(WORD_SZ)) u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .shift  (shift),
        .lut    (lut),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= RUN;
                        x       <= ONE;
                        y       <= over ? LIM_POS : (under ? LIM_NEG : in_data);
                        z       <= '0;
                        cnt     <= '0;
                        out_sat <= over | under;
                    end
                end
                RUN: begin
                    x   <= x_next;
                    y   <= y_next;
                    z   <= z_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        out_data <= z_next;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atanh.sv
// Directed-vector bench for cordic_atanh: latency, accuracy, clamping, back-pressure and reset abort.
module tb_cordic_atanh;

    localparam int TOL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cordic_atanh dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Present op in IDLE, count edges from the accepting edge to out_valid.
    task automatic run_op(input int op, output int res, output logic sat, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1;
        in_data  = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        res = $signed(out_data);
        sat = out_sat;
    endtask

    task automatic check_op(input string name, input int op, input int exp, input logic exp_sat);
        int   res, lat;
        logic sat;
        run_op(op, res, sat, lat);
        vectors++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL %s latency: got %0d, want 17", name, lat);
        end
        vectors++;
        if (iabs(res - exp) > TOL) begin
            errors++;
            $display("FAIL %s out_data: got %0d, want %0d+-%0d", name, res, exp, TOL);
        end
        vectors++;
        if (sat !== exp_sat) begin
            errors++;
            $display("FAIL %s out_sat: got %0b, want %0b", name, sat, exp_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset handshake: in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
        end
        vectors++;
        if (out_data !== 32'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: out_data=%0d out_sat=%0b, want 0/0", out_data, out_sat);
        end
    endtask

    task automatic test_basic();
        check_op("pos_half", 16384, 18000, 1'b0);
        check_op("neg_half", -16384, -18000, 1'b0);
        check_op("zero", 0, 0, 1'b0);
    endtask

    task automatic test_clamp();
        check_op("clamp_pos", 30000, 36000, 1'b1);
        check_op("clamp_neg", -40000, -36000, 1'b1);
        check_op("edge_limit", 26214, 36000, 1'b0);
    endtask

    task automatic test_backpressure();
        int   res, lat, held;
        logic sat;
        out_ready = 1'b0;
        run_op(16384, res, sat, lat);
        vectors++;
        if (lat !== 17 || iabs(res - 18000) > TOL) begin
            errors++;
            $display("FAIL bp first result: lat=%0d data=%0d, want 17/18000", lat, res);
        end
        held = res;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_data  = 8192;
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || $signed(out_data) !== held) begin
                errors++;
                $display("FAIL bp hold cycle %0d: valid=%0b ready=%0b data=%0d, want 1/0/%0d",
                         i, out_valid, in_ready, $signed(out_data), held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp release: in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
        end
        check_op("bp_next", -8192, -8369, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen;
        in_valid = 1'b1;
        in_data  = 16384;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort in reset: valid=%0b data=%0d ready=%0b, want 0/0/1",
                     out_valid, out_data, in_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid || out_data !== 32'd0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort no result: %0d cycles with output activity, want 0", seen);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort in_ready: got %0b, want 1", in_ready);
        end
        check_op("after_abort", 8192, 8369, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
